// File: rtl/fpga_cfg_pkg.sv
// Fabric dimensions, configuration image layout and loader state encoding,
// shared by the loader, fpga_top and the benches.
package fpga_cfg_pkg;

    localparam int WIRE_WIDTH  = 7;
    localparam int LB_CFG_SIZE = 10;
    localparam int FPGA_WIDTH  = 5;
    localparam int FPGA_HEIGHT = 5;
    localparam int WORD_WIDTH  = 32;

    localparam int BRB_BITS = FPGA_HEIGHT * FPGA_WIDTH * WIRE_WIDTH * 12;
    localparam int BSB_BITS = (FPGA_HEIGHT - 1) * (FPGA_WIDTH - 1) * WIRE_WIDTH * WIRE_WIDTH * 12;
    localparam int LB_BITS  = FPGA_WIDTH * FPGA_HEIGHT * LB_CFG_SIZE;
    localparam int IO_BITS  = 2 * WIRE_WIDTH * FPGA_HEIGHT;

    // Image layout, brb at bit 0: {bottomio, topio, rightio, leftio, lb, bsb, brb}
    localparam int BRB_OFS     = 0;
    localparam int BSB_OFS     = BRB_OFS + BRB_BITS;
    localparam int LB_OFS      = BSB_OFS + BSB_BITS;
    localparam int LEFTIO_OFS  = LB_OFS + LB_BITS;
    localparam int RIGHTIO_OFS = LEFTIO_OFS + IO_BITS;
    localparam int TOPIO_OFS   = RIGHTIO_OFS + IO_BITS;
    localparam int BOTIO_OFS   = TOPIO_OFS + IO_BITS;
    localparam int TOTAL_BITS  = BOTIO_OFS + IO_BITS;

    localparam int NUM_WORDS       = (TOTAL_BITS + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int IDX_BITS        = $clog2(NUM_WORDS);
    localparam int SHADOW_IDX_BITS = $clog2(TOTAL_BITS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_ERROR = 2'd3
    } cfg_state_e;

endpackage

// File: rtl/fpga_cfg_loader_if.sv
// Word-wide configuration stream port.
// A word moves on a rising clk edge where cfg_valid and cfg_ready are both high;
// the master holds cfg_data stable while cfg_valid is high, and either side may idle freely.
interface fpga_cfg_loader_if;
    import fpga_cfg_pkg::*;

    logic [WORD_WIDTH-1:0] cfg_data;
    logic                  cfg_valid;
    logic                  cfg_ready;

    modport master (output cfg_data, output cfg_valid, input cfg_ready);
    modport slave  (input cfg_data, input cfg_valid, output cfg_ready);

endinterface

// File: rtl/fpga_cfg_shadow.sv
// Shadow image register: word-indexed writes, bits beyond TOTAL_BITS in the last word are dropped.
module fpga_cfg_shadow
    import fpga_cfg_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  we_i,
    input  logic [IDX_BITS-1:0]   idx_i,
    input  logic [WORD_WIDTH-1:0] data_i,
    output logic [TOTAL_BITS-1:0] shadow_o
);

    logic [TOTAL_BITS-1:0] shadow_q;
    logic [TOTAL_BITS-1:0] shadow_d;
    int                    base;
    int                    pos;

    always_comb begin
        shadow_d = shadow_q;
        base     = int'(idx_i) * WORD_WIDTH;
        pos      = 0;
        if (clr_i) begin
            shadow_d = '0;
        end else if (we_i) begin
            for (int b = 0; b < WORD_WIDTH; b++) begin
                pos = base + b;
                if (pos < TOTAL_BITS) begin
                    shadow_d[pos[SHADOW_IDX_BITS-1:0]] = data_i[b];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign shadow_o = shadow_q;

endmodule

// File: rtl/fpga_cfg_loader.sv
// Streams a checksummed configuration image into a shadow register and commits it to the
// active select buses only after the checksum word matches.
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    fpga_cfg_loader_if.slave       cfg_if,
    input  logic                   cfg_start,
    input  logic                   cfg_clear,
    output logic                   cfg_busy,
    output logic                   cfg_done,
    output logic                   cfg_error,
    output cfg_state_e             cfg_state,
    output logic [BRB_BITS-1:0]    brbselect,
    output logic [BSB_BITS-1:0]    bsbselect,
    output logic [LB_BITS-1:0]     lbselect,
    output logic [IO_BITS-1:0]     leftioselect,
    output logic [IO_BITS-1:0]     rightioselect,
    output logic [IO_BITS-1:0]     topioselect,
    output logic [IO_BITS-1:0]     bottomioselect
);

    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_WORDS - 1);

    cfg_state_e            state_q;
    logic [IDX_BITS-1:0]   idx_q;
    logic [WORD_WIDTH-1:0] csum_q;
    logic [TOTAL_BITS-1:0] active_q;
    logic                  done_q;
    logic                  error_q;
    logic [TOTAL_BITS-1:0] shadow;
    logic                  accepting;
    logic                  xfer;

    assign accepting        = (state_q == ST_LOAD) || (state_q == ST_CHECK);
    assign cfg_if.cfg_ready = accepting;
    assign xfer             = cfg_if.cfg_valid && accepting;

    // A start on the same edge as a transfer wins, so the word never reaches the shadow.
    fpga_cfg_shadow u_shadow (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (cfg_start),
        .we_i     (xfer && (state_q == ST_LOAD) && !cfg_start),
        .idx_i    (idx_q),
        .data_i   (cfg_if.cfg_data),
        .shadow_o (shadow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            csum_q   <= '0;
            active_q <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (cfg_start) begin
                state_q <= ST_LOAD;
                idx_q   <= '0;
                csum_q  <= '0;
                error_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_LOAD: begin
                        if (xfer) begin
                            csum_q <= csum_q ^ cfg_if.cfg_data;
                            idx_q  <= idx_q + 1'b1;
                            if (idx_q == LAST_IDX) begin
                                state_q <= ST_CHECK;
                            end
                        end
                    end
                    ST_CHECK: begin
                        if (xfer) begin
                            if (cfg_if.cfg_data == csum_q) begin
                                active_q <= shadow;
                                done_q   <= 1'b1;
                                state_q  <= ST_IDLE;
                            end else begin
                                error_q <= 1'b1;
                                state_q <= ST_ERROR;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            // Placed last so a clear overrides a commit landing on the same edge.
            if (cfg_clear) begin
                active_q <= '0;
            end
        end
    end

    assign cfg_busy       = accepting;
    assign cfg_done       = done_q;
    assign cfg_error      = error_q;
    assign cfg_state      = state_q;
    assign brbselect      = active_q[BRB_OFS +: BRB_BITS];
    assign bsbselect      = active_q[BSB_OFS +: BSB_BITS];
    assign lbselect       = active_q[LB_OFS +: LB_BITS];
    assign leftioselect   = active_q[LEFTIO_OFS +: IO_BITS];
    assign rightioselect  = active_q[RIGHTIO_OFS +: IO_BITS];
    assign topioselect    = active_q[TOPIO_OFS +: IO_BITS];
    assign bottomioselect = active_q[BOTIO_OFS +: IO_BITS];

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Randomized scoreboard bench for fpga_cfg_loader: stimulus pushes expected commit/error
// events, a negedge monitor pops them when the DUT pulses cfg_done or raises cfg_error.
module tb_fpga_cfg_loader;
    import fpga_cfg_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpga_cfg_loader_if cfg_if();

    logic                  cfg_start = 1'b0;
    logic                  cfg_clear = 1'b0;
    logic                  cfg_busy;
    logic                  cfg_done;
    logic                  cfg_error;
    cfg_state_e            cfg_state;
    logic [BRB_BITS-1:0]   brbselect;
    logic [BSB_BITS-1:0]   bsbselect;
    logic [LB_BITS-1:0]    lbselect;
    logic [IO_BITS-1:0]    leftioselect;
    logic [IO_BITS-1:0]    rightioselect;
    logic [IO_BITS-1:0]    topioselect;
    logic [IO_BITS-1:0]    bottomioselect;
    logic [TOTAL_BITS-1:0] sel_all;

    fpga_cfg_loader dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_if         (cfg_if),
        .cfg_start      (cfg_start),
        .cfg_clear      (cfg_clear),
        .cfg_busy       (cfg_busy),
        .cfg_done       (cfg_done),
        .cfg_error      (cfg_error),
        .cfg_state      (cfg_state),
        .brbselect      (brbselect),
        .bsbselect      (bsbselect),
        .lbselect       (lbselect),
        .leftioselect   (leftioselect),
        .rightioselect  (rightioselect),
        .topioselect    (topioselect),
        .bottomioselect (bottomioselect)
    );

    assign sel_all = {bottomioselect, topioselect, rightioselect, leftioselect,
                      lbselect, bsbselect, brbselect};

    // ---------------- scoreboard ----------------
    // MSB of each entry: 1 = error event expected, 0 = commit expected; low bits = selects.
    logic [TOTAL_BITS:0]   exp_q[$];
    logic [TOTAL_BITS-1:0] model_active = '0;
    logic [NUM_WORDS*WORD_WIDTH-1:0] model_full;
    logic [WORD_WIDTH-1:0] img_words[$];
    int checks = 0;
    int errors = 0;
    logic prev_err = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_img(input string name, input logic [TOTAL_BITS-1:0] act,
                           input logic [TOTAL_BITS-1:0] exp);
        int nd;
        int first;
        checks++;
        nd    = $countones(act ^ exp);
        first = -1;
        if (nd != 0 || (^act === 1'bx)) begin
            errors++;
            for (int i = TOTAL_BITS - 1; i >= 0; i--) begin
                if (act[i] !== exp[i]) first = i;
            end
            $display("FAIL %s: %0d bits differ, first at bit %0d got %b expected %b",
                     name, nd, first, act[(first < 0) ? 0 : first], exp[(first < 0) ? 0 : first]);
        end
    endtask

    // Monitor: every done pulse or error rise must match the oldest expected event.
    always @(negedge clk) begin
        if (cfg_done) begin
            if (exp_q.size() == 0) begin
                chk("done_unexpected", 64'(cfg_done), 64'd0);
            end else begin
                chk("done_event_kind", 64'(exp_q[0][TOTAL_BITS]), 64'd0);
                chk_img("commit_image", sel_all, exp_q[0][TOTAL_BITS-1:0]);
                void'(exp_q.pop_front());
            end
        end
        if (cfg_error && !prev_err) begin
            if (exp_q.size() == 0) begin
                chk("error_unexpected", 64'(cfg_error), 64'd0);
            end else begin
                chk("error_event_kind", 64'(exp_q[0][TOTAL_BITS]), 64'd1);
                chk_img("error_held_image", sel_all, exp_q[0][TOTAL_BITS-1:0]);
                void'(exp_q.pop_front());
            end
        end
        prev_err <= cfg_error;
    end

    // ---------------- driver tasks (called right after a negedge) ----------------
    task automatic pulse_start();
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic send_word(input logic [WORD_WIDTH-1:0] d, input bit gaps);
        int n;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
                cfg_if.cfg_valid = 1'b0;
                @(negedge clk);
            end
        end
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_data  = d;
        n = 0;
        while (!cfg_if.cfg_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("ready_timeout", 64'(cfg_if.cfg_ready), 64'd1);
        else @(negedge clk);
    endtask

    task automatic wait_drained(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Reference model: image = word stream laid end to end, truncated to TOTAL_BITS;
    // checksum = XOR of all full words, pad bits included.
    task automatic send_image(input bit do_start, input bit gaps, input bit bad, input bit clr_csum);
        logic [WORD_WIDTH-1:0] csum;
        logic [TOTAL_BITS-1:0] image;
        csum       = '0;
        model_full = '0;
        foreach (img_words[k]) begin
            csum = csum ^ img_words[k];
            model_full[k*WORD_WIDTH +: WORD_WIDTH] = img_words[k];
        end
        image = model_full[TOTAL_BITS-1:0];
        if (bad) csum = csum ^ (WORD_WIDTH'(1) << $urandom_range(0, WORD_WIDTH - 1));
        if (do_start) pulse_start();
        foreach (img_words[k]) send_word(img_words[k], gaps);
        if (bad) begin
            exp_q.push_back({1'b1, model_active});
        end else begin
            model_active = clr_csum ? '0 : image;
            exp_q.push_back({1'b0, model_active});
        end
        cfg_clear = clr_csum;
        send_word(csum, gaps);
        cfg_clear        = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        wait_drained("event_seen");
    endtask

    task automatic fill_counting();
        img_words.delete();
        for (int k = 0; k < NUM_WORDS; k++) img_words.push_back(WORD_WIDTH'(k));
    endtask

    task automatic fill_random();
        img_words.delete();
        for (int k = 0; k < NUM_WORDS; k++) img_words.push_back(WORD_WIDTH'($urandom));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_data  = '0;
        repeat (3) @(negedge clk);

        // 1: reset values, and no acceptance without a start
        chk("rst_ready", 64'(cfg_if.cfg_ready), 64'd0);
        chk("rst_busy", 64'(cfg_busy), 64'd0);
        chk("rst_done", 64'(cfg_done), 64'd0);
        chk("rst_error", 64'(cfg_error), 64'd0);
        chk_img("rst_selects", sel_all, '0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_ready", 64'(cfg_if.cfg_ready), 64'd0);
        chk("idle_state", 64'(cfg_state), 64'(ST_IDLE));

        // 2: good counting image
        fill_counting();
        send_image(1'b1, 1'b0, 1'b0, 1'b0);
        chk("brb_63_32", 64'(brbselect[63:32]), 64'd1);
        chk("botio_69_64", 64'(bottomioselect[69:64]), 64'(376 % 64));
        chk("after_commit_state", 64'(cfg_state), 64'(ST_IDLE));
        chk("after_commit_ready", 64'(cfg_if.cfg_ready), 64'd0);

        // 3: bad checksum keeps the committed image
        fill_random();
        send_image(1'b1, 1'b0, 1'b1, 1'b0);
        chk("bad_error", 64'(cfg_error), 64'd1);
        chk("bad_state", 64'(cfg_state), 64'(ST_ERROR));
        chk("bad_ready", 64'(cfg_if.cfg_ready), 64'd0);
        chk_img("bad_selects_kept", sel_all, model_active);
        pulse_start();
        chk("restart_error", 64'(cfg_error), 64'd0);
        chk("restart_ready", 64'(cfg_if.cfg_ready), 64'd1);
        chk("restart_busy", 64'(cfg_busy), 64'd1);

        // 4: clear mid-load leaves the FSM alone; then the counting image with valid gaps
        cfg_clear = 1'b1;
        @(negedge clk);
        cfg_clear    = 1'b0;
        model_active = '0;
        chk_img("clear_selects", sel_all, model_active);
        chk("clear_keeps_load", 64'(cfg_state), 64'(ST_LOAD));
        fill_counting();
        send_image(1'b1, 1'b1, 1'b0, 1'b0);
        chk("gaps_brb_63_32", 64'(brbselect[63:32]), 64'd1);
        chk("gaps_done_low", 64'(cfg_done), 64'd0);

        // 5: abort after 100 words, restart on an edge that also carries a word
        pulse_start();
        for (int k = 0; k < 100; k++) send_word(WORD_WIDTH'($urandom), 1'b0);
        cfg_if.cfg_data = WORD_WIDTH'($urandom);
        pulse_start();
        img_words.delete();
        for (int k = 0; k < NUM_WORDS; k++) img_words.push_back('1);
        send_image(1'b0, 1'b0, 1'b0, 1'b0);
        chk_img("ones_selects", sel_all, {TOTAL_BITS{1'b1}});

        // 6: clear on the checksum edge, then async reset in the middle of a load
        fill_random();
        send_image(1'b1, 1'b0, 1'b0, 1'b1);
        chk_img("clear_commit_selects", sel_all, '0);
        fill_random();
        send_image(1'b1, 1'b0, 1'b0, 1'b0);
        pulse_start();
        for (int k = 0; k < 50; k++) send_word(WORD_WIDTH'($urandom), 1'b0);
        #2 rst_n = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        model_active     = '0;
        #1;
        chk("async_rst_state", 64'(cfg_state), 64'(ST_IDLE));
        chk("async_rst_ready", 64'(cfg_if.cfg_ready), 64'd0);
        chk_img("async_rst_selects", sel_all, model_active);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", 64'(cfg_busy), 64'd0);
        chk_img("post_rst_selects", sel_all, model_active);

        wait_drained("scoreboard_empty");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
